// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: unit-select codes,
// sequencer state encoding and default sizing.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 4;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   // Bit n of the result is the enable of the unit whose select code is n.
   function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
      unit_onehot = 4'b0001 << unit;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB distinguishes full from empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DATA_W = 2 * DEFAULT_WIDTH + 4,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr_reg;
   logic [AW:0]       rd_ptr_reg;
   logic              push_ok;
   logic              pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // Head is read combinationally so the sequencer can pop and load in one edge.
   assign pop_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 16-bit ALU: buffers commands, issues them to one
// unit for a single cycle, captures the registered result and hands it on.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [3:0]       cmd_fun,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [1:0]       ALU_FUN,
   output logic             Arith_Enable,
   output logic             Logic_Enable,
   output logic             CMP_Enable,
   output logic             Shift_Enable,
   input  logic [WIDTH-1:0] Arith_Out,
   input  logic [WIDTH-1:0] Logic_Out,
   input  logic [WIDTH-1:0] CMP_Out,
   input  logic [WIDTH-1:0] Shift_Out,
   input  logic             Arith_Flag,
   input  logic             Logic_Flag,
   input  logic             CMP_Flag,
   input  logic             Shift_Flag,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [1:0]       res_unit,
   output logic             res_err
);

   localparam int CMD_W = 2 * WIDTH + 4;

   logic [CMD_W-1:0] push_data;
   logic [CMD_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   state_t           state_reg;
   state_t           state_next;
   logic             load;
   logic             capture;
   logic             res_done;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [1:0]       fun_reg;
   logic [1:0]       unit_reg;
   logic [WIDTH-1:0] res_data_reg;
   logic [1:0]       res_unit_reg;
   logic             res_err_reg;
   logic             res_valid_reg;

   logic [WIDTH-1:0] sel_out;
   logic             sel_flag;
   logic [3:0]       enable_vec;

   // Queue entry layout: {fun[3:0], a, b}
   assign push_data = {cmd_fun, cmd_a, cmd_b};
   assign cmd_ready = !fifo_full;

   alu_cmd_fifo #(
      .DATA_W (CMD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_valid && !fifo_full),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      load       = 1'b0;
      capture    = 1'b0;
      res_done   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               load       = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture    = 1'b1;
            state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_done = 1'b1;
               // Refill straight from the queue so results keep a 3-cycle cadence.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  load       = 1'b1;
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_out  = Arith_Out;
      sel_flag = Arith_Flag;
      case (unit_reg)
         UNIT_ARITH: begin sel_out = Arith_Out; sel_flag = Arith_Flag; end
         UNIT_LOGIC: begin sel_out = Logic_Out; sel_flag = Logic_Flag; end
         UNIT_CMP:   begin sel_out = CMP_Out;   sel_flag = CMP_Flag;   end
         UNIT_SHIFT: begin sel_out = Shift_Out; sel_flag = Shift_Flag; end
         default:    begin sel_out = Arith_Out; sel_flag = Arith_Flag; end
      endcase
   end

   // Enables come straight from the state register so reset kills them at once.
   assign enable_vec   = (state_reg == ST_ISSUE) ? unit_onehot(unit_reg) : 4'b0000;
   assign Arith_Enable = enable_vec[UNIT_ARITH];
   assign Logic_Enable = enable_vec[UNIT_LOGIC];
   assign CMP_Enable   = enable_vec[UNIT_CMP];
   assign Shift_Enable = enable_vec[UNIT_SHIFT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         fun_reg       <= '0;
         unit_reg      <= '0;
         res_data_reg  <= '0;
         res_unit_reg  <= '0;
         res_err_reg   <= 1'b0;
         res_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            b_reg    <= head[WIDTH-1:0];
            a_reg    <= head[2*WIDTH-1:WIDTH];
            fun_reg  <= head[CMD_W-3:CMD_W-4];
            unit_reg <= head[CMD_W-1:CMD_W-2];
         end
         if (capture) begin
            res_data_reg  <= sel_out;
            res_unit_reg  <= unit_reg;
            res_err_reg   <= !sel_flag;
            res_valid_reg <= 1'b1;
         end else if (res_done) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

   assign A         = a_reg;
   assign B         = b_reg;
   assign ALU_FUN   = fun_reg;
   assign res_data  = res_data_reg;
   assign res_unit  = res_unit_reg;
   assign res_err   = res_err_reg;
   assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with simple registered unit models.
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [3:0]  cmd_fun;
   logic [15:0] A;
   logic [15:0] B;
   logic [1:0]  ALU_FUN;
   logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
   logic [15:0] Arith_Out, Logic_Out, CMP_Out, Shift_Out;
   logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [1:0]  res_unit;
   logic        res_err;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  unit;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_results = 0;
   int   cyc = 0;
   int   last_hs = -1;
   bit   spacing_on = 0;

   alu_op_sequencer #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
      .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
      .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
      .Arith_Out(Arith_Out), .Logic_Out(Logic_Out),
      .CMP_Out(CMP_Out), .Shift_Out(Shift_Out),
      .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
      .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit models: outputs are zero unless enabled the cycle before, so a
   // capture on the wrong cycle shows up as a wrong value and an error flag.
   function automatic logic [15:0] arith_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
      case (f)
         2'b00:   arith_f = a + b;
         2'b01:   arith_f = a - b;
         2'b10:   arith_f = a * b;
         default: arith_f = a;
      endcase
   endfunction

   function automatic logic [15:0] logic_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
      case (f)
         2'b00:   logic_f = a & b;
         2'b01:   logic_f = a | b;
         2'b10:   logic_f = a ^ b;
         default: logic_f = ~a;
      endcase
   endfunction

   function automatic logic [15:0] cmp_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
      case (f)
         2'b00:   cmp_f = {15'b0, a == b};
         2'b01:   cmp_f = {15'b0, $signed(a) > $signed(b)};
         2'b10:   cmp_f = {15'b0, $signed(a) < $signed(b)};
         default: cmp_f = 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] shift_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
      case (f)
         2'b00:   shift_f = a >> b[3:0];
         2'b01:   shift_f = a << b[3:0];
         2'b10:   shift_f = $signed(a) >>> b[3:0];
         default: shift_f = a;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         Arith_Out <= '0; Logic_Out <= '0; CMP_Out <= '0; Shift_Out <= '0;
         Arith_Flag <= 1'b0; Logic_Flag <= 1'b0; CMP_Flag <= 1'b0; Shift_Flag <= 1'b0;
      end else begin
         Arith_Out  <= Arith_Enable ? arith_f(A, B, ALU_FUN) : 16'h0000;
         Logic_Out  <= Logic_Enable ? logic_f(A, B, ALU_FUN) : 16'h0000;
         CMP_Out    <= CMP_Enable   ? cmp_f(A, B, ALU_FUN)   : 16'h0000;
         Shift_Out  <= Shift_Enable ? shift_f(A, B, ALU_FUN) : 16'h0000;
         Arith_Flag <= Arith_Enable;
         Logic_Flag <= Logic_Enable;
         CMP_Flag   <= CMP_Enable;
         // Left shift is reported as an error by this shift-unit model.
         Shift_Flag <= Shift_Enable && (ALU_FUN != 2'b01);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: scoreboard compare, hold stability, enable one-hot and pulse width.
   logic [3:0]  prev_en = 4'b0;
   bit          prev_stall = 0;
   logic [15:0] prev_data;
   logic [1:0]  prev_unit;
   logic        prev_err;

   always @(negedge clk) begin
      logic [3:0] en;
      exp_t e;
      en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
      if (rst) begin
         prev_stall = 0;
         prev_en    = 4'b0;
      end else begin
         if (en != 4'b0) begin
            check("enable_onehot", $countones(en), 1);
            check("enable_single_cycle", {28'b0, prev_en}, 0);
         end
         prev_en = en;
         if (prev_stall) begin
            check("hold_valid", res_valid, 1);
            check("hold_data", {13'b0, prev_err, prev_unit, prev_data}, {13'b0, res_err, res_unit, res_data});
         end
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         prev_unit  = res_unit;
         prev_err   = res_err;
         if (res_valid && res_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
               check("unexpected_result", {16'b0, res_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("res_data", res_data, e.data);
               check("res_unit", res_unit, e.unit);
               check("res_err", res_err, e.err);
               $display("result data=%04h unit=%0d err=%0d (exp %04h/%0d/%0d)",
                        res_data, res_unit, res_err, e.data, e.unit, e.err);
            end
            if (spacing_on) begin
               if (last_hs >= 0) check("result_spacing", cyc - last_hs, 3);
               last_hs = cyc;
            end
         end
      end
   end

   task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                           input logic [15:0] exp_data, input logic exp_err);
      int waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_fun = fun;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) check("push_timeout", 0, 1);
      e.data = exp_data; e.unit = fun[3:2]; e.err = exp_err;
      exp_q.push_back(e);
      $display("push a=%04h b=%04h fun=%04b", a, b, fun);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_res_valid(input string name);
      int waited;
      waited = 0;
      while (!res_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!res_valid) check(name, 0, 1);
   endtask

   task automatic wait_drain(input string name);
      int waited;
      waited = 0;
      while ((exp_q.size() != 0 || res_valid) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fun = '0; res_ready = 1'b0;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 0);
      check("rst_operands", {A, B}, 0);
      check("rst_fun", ALU_FUN, 0);
      check("rst_result", {res_err, res_unit, res_data}, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Reset while a result is held and another command is queued.
      push_cmd(16'h0001, 16'h0001, 4'b0000, 16'h0002, 1'b0);
      push_cmd(16'h0002, 16'h0002, 4'b0000, 16'h0004, 1'b0);
      wait_res_valid("rst_hold_reached");
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_res_valid", res_valid, 0);
      check("midrst_enables", {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_res_data", res_data, 0);
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("post_rst_cmd_ready", cmd_ready, 1);
      res_ready = 1'b1;
      base = n_results;
      repeat (12) @(posedge clk);
      check("rst_fifo_flushed", n_results - base, 0);

      // Single logic op: latency and issue window.
      push_cmd(16'h00F0, 16'h0FF0, 4'b0100, 16'h00F0, 1'b0);
      check("lat_e1_valid", res_valid, 0);
      check("lat_e1_enable", Logic_Enable, 0);
      @(posedge clk); #1;
      check("lat_issue_enable", Logic_Enable, 1);
      check("lat_issue_fun", ALU_FUN, 2'b00);
      check("lat_issue_ops", {A, B}, 32'h00F0_0FF0);
      @(posedge clk); #1;
      check("lat_capture_enable", Logic_Enable, 0);
      check("lat_capture_valid", res_valid, 0);
      @(posedge clk); #1;
      check("lat_e4_valid", res_valid, 1);
      check("lat_e4_data", {res_err, res_unit, res_data}, {1'b0, 2'b01, 16'h00F0});
      wait_drain("drain_logic");

      // Back-to-back mixed units, one result every 3 cycles.
      spacing_on = 1; last_hs = -1;
      push_cmd(16'h0004, 16'h0003, 4'b0000, 16'h0007, 1'b0);
      push_cmd(16'h00FF, 16'h0F0F, 4'b0110, 16'h0FF0, 1'b0);
      push_cmd(16'hFFFF, 16'h0001, 4'b1001, 16'h0000, 1'b0);
      push_cmd(16'h8000, 16'h0004, 4'b1110, 16'hF800, 1'b0);
      wait_drain("drain_b2b");
      spacing_on = 0;

      // Backpressure until the FIFO fills, then drain everything in order.
      @(posedge clk); #1 res_ready = 1'b0;
      push_cmd(16'h0005, 16'h0007, 4'b0001, 16'hFFFE, 1'b0);
      push_cmd(16'h1200, 16'h0034, 4'b0101, 16'h1234, 1'b0);
      push_cmd(16'hFFFE, 16'h0003, 4'b1010, 16'h0001, 1'b0);
      push_cmd(16'h00F0, 16'h0004, 4'b1100, 16'h000F, 1'b0);
      push_cmd(16'h0010, 16'h0011, 4'b0010, 16'h0110, 1'b0);
      fork
         push_cmd(16'h1234, 16'h1234, 4'b1000, 16'h0001, 1'b0);
         begin
            repeat (4) @(posedge clk);
            #1;
            check("full_cmd_ready", cmd_ready, 0);
            check("full_res_valid", res_valid, 1);
            res_ready = 1'b1;
         end
      join
      wait_drain("drain_full");

      // Shift unit reports an error flag.
      push_cmd(16'h0001, 16'h0003, 4'b1101, 16'h0008, 1'b1);
      wait_drain("drain_flag");

      // Push coinciding with the HOLD->ISSUE pop at occupancy 1.
      @(posedge clk); #1 res_ready = 1'b0;
      push_cmd(16'h1111, 16'h2222, 4'b0000, 16'h3333, 1'b0);
      push_cmd(16'h00FF, 16'h0000, 4'b0111, 16'hFF00, 1'b0);
      wait_res_valid("simul_hold_reached");
      @(posedge clk); #1;
      begin
         exp_t e;
         res_ready = 1'b1;
         cmd_valid = 1'b1; cmd_a = 16'h0000; cmd_b = 16'h0001; cmd_fun = 4'b0001;
         check("simul_cmd_ready", cmd_ready, 1);
         e.data = 16'hFFFF; e.unit = 2'b00; e.err = 1'b0;
         exp_q.push_back(e);
         $display("push a=0000 b=0001 fun=0001 (with pop)");
         @(posedge clk); #1 cmd_valid = 1'b0;
         check("simul_state_issue", Arith_Enable | Logic_Enable, 1);
      end
      wait_drain("drain_simul");

      repeat (5) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command front-end for the 16-bit signed ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each command into one-hot unit enables plus a 2-bit sub-function, and drives the shared operand bus into the arithmetic, logic, compare and shift units.
- Captures the selected unit's registered result one cycle later and presents it downstream with its own valid/ready handshake.

Parameters:
- WIDTH, 16, operand and result width.
- DEPTH, 4, command FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] sub-function.
- A  out  WIDTH  operand A to the units.
- B  out  WIDTH  operand B to the units.
- ALU_FUN  out  2  sub-function to the units.
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out  1 each  one-hot unit enables.
- Arith_Out, Logic_Out, CMP_Out, Shift_Out  in  WIDTH each  registered unit results.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  registered unit flags.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts.
- res_data  out  WIDTH  captured result.
- res_unit  out  2  unit that produced res_data.
- res_err  out  1  selected unit's flag was low at capture.

Behaviour:
- Reset is asynchronous, active-high. While rst is high or after it:
  - FIFO is empty; state is IDLE.
  - All enables, A, B, ALU_FUN, res_data, res_unit, res_err and res_valid are 0.
  - cmd_ready is 1.
- Reset asserted mid-operation aborts the in-flight command and discards the FIFO contents; the enables drop immediately.
- Command push when cmd_valid && cmd_ready. cmd_ready = !fifo_full, a registered-state function only, with no combinational path from res_ready.
- A push into a full FIFO cannot occur. A push and a pop in the same cycle are legal at any occupancy from 1 to DEPTH-1 and leave the count unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB compare.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE:
  - All enables are 0.
  - If the FIFO is non-empty: pop the head, register A/B/ALU_FUN/unit from it, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Exactly one enable is high, per unit select; A/B/ALU_FUN are stable.
  - Go to CAPTURE.
- CAPTURE (exactly 1 cycle):
  - All enables are 0; the unit's output is valid this cycle.
  - At the clock edge: res_data <= selected Out, res_unit <= unit, res_err <= !selected Flag, res_valid <= 1. Go to HOLD.
- HOLD:
  - res_valid=1 and res_data, res_unit, res_err are held stable until res_ready.
  - On res_valid && res_ready:
    - res_valid <= 0.
    - If the FIFO is non-empty: pop, load the operands, go directly to ISSUE (back-to-back).
    - Otherwise: go to IDLE.
- Timing:
  - Latency from a push into an empty idle block to res_valid is 4 edges (push, pop, issue, capture).
  - Sustained throughput is 1 result per 3 cycles with res_ready held high.
- A, B and ALU_FUN hold their last values outside ISSUE; only the enables gate the units.
- A command pushed in the same cycle the FSM pops the last entry is not lost; it is popped on a later cycle.
- res_data is passed through unmodified with no sign manipulation. Signedness belongs to the units.

Decomposition:
- Shared package alu_pkg:
  - Unit-select encodings UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
  - FSM state encoding.
  - Default WIDTH.
- One sub-module, alu_cmd_fifo:
  - Synchronous FIFO, WIDTH*2+4 bits wide, DEPTH entries.
  - Ports: push/pop/full/empty, same clk/rst.
- Decode, FSM and result capture stay in alu_op_sequencer.

Test Plan:
- Reset mid-HOLD: assert rst while res_valid=1 -> res_valid, all enables and the FIFO clear the same cycle; cmd_ready=1 after release.
- Logic op: push A=16'h00F0, B=16'h0FF0, fun=4'b0100 with a logic-unit model -> Logic_Enable high for exactly 1 cycle with ALU_FUN=00; res_data=16'h00F0, res_unit=01, res_err=0, 4 edges after the push.
- Back-to-back: push 4 mixed commands (arith, logic, cmp, shift) with res_ready=1 -> results in push order, one every 3 cycles; the enables are one-hot, never overlapping.
- Backpressure/full: res_ready=0, push 6 commands with DEPTH=4 -> 1 command in HOLD, 4 in the FIFO, cmd_ready=0 afterwards; the 6th push stalls. res_data stays stable while res_ready=0. Raising res_ready drains all 6 results in order.
- Flag error: unit model drives Shift_Flag=0 during CAPTURE for fun=4'b1101 -> res_err=1, res_unit=11.
- Simultaneous push/pop: with the FIFO holding 1 entry, push in the same cycle as the HOLD->ISSUE pop -> count stays 1; no command is dropped or duplicated, as checked by a scoreboard.
